// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared types and defaults for the packet assembler
package pkt_pkg;

    localparam int PKT_BYTES_DEFAULT = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        EMIT,
        DROP
    } asm_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// rtl/packet_assembler.sv - byte-stream deframer into one PKT_BYTES packet with frame statistics
// Optional XOR trailer check enabled by defining PKT_CHECKSUM_EN.
module packet_assembler
    import pkt_pkg::*;
#(
    parameter int PKT_BYTES = PKT_BYTES_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             byteIn,
    input  logic                   byteValid,
    input  logic                   byteLast,
    output logic                   byteReady,
    output logic [PKT_BYTES*8-1:0] packetOut,
    output logic                   packetOutValid,
    output logic [CNT_W-1:0]       goodCount,
    output logic [CNT_W-1:0]       runtCount,
    output logic [CNT_W-1:0]       longCount
`ifdef PKT_CHECKSUM_EN
    ,
    output logic [CNT_W-1:0]       csumErrCount
`endif
);

    localparam int CW = $clog2(PKT_BYTES + 1);

    asm_state_t             state;
    logic [CW-1:0]          cnt;
    logic [PKT_BYTES*8-1:0] sreg;
    logic                   accept;
    logic                   at_payload_end;
    logic                   inc_good;
    logic                   inc_runt;
    logic                   inc_long;

    assign byteReady      = !rst && (state != EMIT);
    assign accept         = byteValid && byteReady;
    assign at_payload_end = (cnt == CW'(PKT_BYTES - 1));

`ifdef PKT_CHECKSUM_EN
    byte_t csum;
    logic  csum_ok;
    logic  inc_csum;

    // The trailer follows the payload, so any last inside the payload is a runt.
    assign csum_ok  = (byteIn == csum);
    assign inc_runt = accept && byteLast && ((state == IDLE) || (state == COLLECT));
    assign inc_long = accept && !byteLast && (state == CHECK);
    assign inc_good = accept && byteLast && (state == CHECK) && csum_ok;
    assign inc_csum = accept && byteLast && (state == CHECK) && !csum_ok;

    sat_counter #(.CNT_W(CNT_W)) u_csum (.clk(clk), .rst(rst), .inc(inc_csum), .count(csumErrCount));
`else
    assign inc_runt = accept && byteLast &&
                      ((state == IDLE) || ((state == COLLECT) && !at_payload_end));
    assign inc_long = accept && !byteLast && (state == COLLECT) && at_payload_end;
    assign inc_good = accept && byteLast && (state == COLLECT) && at_payload_end;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            sreg           <= '0;
            packetOut      <= '0;
            packetOutValid <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            packetOutValid <= inc_good;
            if (inc_good) begin
`ifdef PKT_CHECKSUM_EN
                packetOut <= sreg;
`else
                packetOut <= {sreg[PKT_BYTES*8-9:0], byteIn};
`endif
            end
            // Only payload bytes enter the shift register; the trailer never does.
            if (accept && ((state == IDLE) || (state == COLLECT))) begin
                sreg <= {sreg[PKT_BYTES*8-9:0], byteIn};
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= CW'(1);
`ifdef PKT_CHECKSUM_EN
                        csum <= byteIn;
`endif
                        if (!byteLast) state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
`ifdef PKT_CHECKSUM_EN
                        csum <= csum ^ byteIn;
`endif
                        if (byteLast) begin
                            state <= inc_good ? EMIT : IDLE;
                        end else if (at_payload_end) begin
`ifdef PKT_CHECKSUM_EN
                            state <= CHECK;
`else
                            state <= DROP;
`endif
                        end
                    end
                end
`ifdef PKT_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (!byteLast)    state <= DROP;
                        else if (csum_ok) state <= EMIT;
                        else              state <= IDLE;
                    end
                end
`endif
                EMIT: state <= IDLE;
                DROP: begin
                    if (accept && byteLast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_good (.clk(clk), .rst(rst), .inc(inc_good), .count(goodCount));
    sat_counter #(.CNT_W(CNT_W)) u_runt (.clk(clk), .rst(rst), .inc(inc_runt), .count(runtCount));
    sat_counter #(.CNT_W(CNT_W)) u_long (.clk(clk), .rst(rst), .inc(inc_long), .count(longCount));

endmodule

// File: tb/tb_packet_assembler.sv
// tb/tb_packet_assembler.sv - randomized frame-level bench for packet_assembler
module tb_packet_assembler;

    localparam int PB = 16;
`ifdef PKT_CHECKSUM_EN
    localparam int FRAME = PB + 1;
`else
    localparam int FRAME = PB;
`endif
    localparam int SAT_MAX = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   byteIn = '0;
    logic         byteValid = 1'b0;
    logic         byteLast = 1'b0;
    logic         byteReady;
    logic [127:0] packetOut;
    logic         packetOutValid;
    logic [15:0]  goodCount, runtCount, longCount;
    logic         s_ready, s_valid;
    logic [127:0] s_pkt;
    logic [3:0]   s_good, s_runt, s_long;
`ifdef PKT_CHECKSUM_EN
    logic [15:0]  csumErrCount;
    logic [3:0]   s_csum;
`endif

    always #5 clk = ~clk;

    packet_assembler dut (
        .clk(clk), .rst(rst), .byteIn(byteIn), .byteValid(byteValid), .byteLast(byteLast),
        .byteReady(byteReady), .packetOut(packetOut), .packetOutValid(packetOutValid),
        .goodCount(goodCount), .runtCount(runtCount), .longCount(longCount)
`ifdef PKT_CHECKSUM_EN
        , .csumErrCount(csumErrCount)
`endif
    );

    // Narrow-counter twin fed the same stream so saturation is reached quickly.
    packet_assembler #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .byteIn(byteIn), .byteValid(byteValid), .byteLast(byteLast),
        .byteReady(s_ready), .packetOut(s_pkt), .packetOutValid(s_valid),
        .goodCount(s_good), .runtCount(s_runt), .longCount(s_long)
`ifdef PKT_CHECKSUM_EN
        , .csumErrCount(s_csum)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   cur[$];
    logic [7:0]   fr[$];
    int           m_good, m_runt, m_long, m_csum;
    logic         exp_valid;
    logic [127:0] last_pkt;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > SAT_MAX) ? SAT_MAX : x;
    endfunction

    // Frame classification from its total length and, with the trailer, the payload XOR.
    task automatic classify();
        logic [127:0] p;
        logic [7:0]   x;
        int n;
        n = cur.size();
        p = '0;
        x = '0;
        if (n < FRAME) begin
            m_runt++;
        end else if (n > FRAME) begin
            m_long++;
        end else begin
            for (int i = 0; i < PB; i++) begin
                p = {p[119:0], cur[i]};
                x = x ^ cur[i];
            end
            if ((FRAME == PB) || (x == cur[PB])) begin
                m_good++;
                exp_valid = 1'b1;
                last_pkt  = p;
            end else begin
                m_csum++;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l, output logic acc);
        @(negedge clk);
        chk("pkt_valid", packetOutValid, exp_valid);
        chk("pkt_data", packetOut, last_pkt);
        chk("ready", byteReady, !exp_valid);
        chk("sat_twin_valid", s_valid, exp_valid);
        chk("sat_twin_ready", s_ready, !exp_valid);
        byteValid = v;
        byteIn    = d;
        byteLast  = v ? l : 1'($urandom);
        acc       = v && byteReady;
        exp_valid = 1'b0;
        if (acc) begin
            cur.push_back(d);
            if (l) begin
                classify();
                cur.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, acc);
    endtask

    task automatic send(input int pct, input logic with_last);
        logic acc;
        int   tries;
        for (int i = 0; i < fr.size(); i++) begin
            tries = 0;
            do begin
                step(($urandom_range(99) < pct) ? 1'b1 : 1'b0, fr[i],
                     with_last && (i == fr.size() - 1), acc);
                tries++;
            end while (!acc && tries < 200);
            if (!acc) begin
                chk("byte_accept_timeout", 1'b0, 1'b1);
                return;
            end
        end
    endtask

    task automatic make_frame(input int len);
        fr.delete();
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    endtask

    // A FRAME-long frame whose trailer (if any) is correct.
    task automatic make_good();
        logic [7:0] x;
        x = '0;
        make_frame(PB);
        foreach (fr[i]) x = x ^ fr[i];
        if (FRAME > PB) fr.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        byteValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cur.delete();
        m_good = 0; m_runt = 0; m_long = 0; m_csum = 0;
        exp_valid = 1'b0;
        last_pkt  = '0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_good"}, goodCount, m_good);
        chk({tag, "_runt"}, runtCount, m_runt);
        chk({tag, "_long"}, longCount, m_long);
        chk({tag, "_good_sat"}, s_good, sat(m_good));
        chk({tag, "_runt_sat"}, s_runt, sat(m_runt));
        chk({tag, "_long_sat"}, s_long, sat(m_long));
`ifdef PKT_CHECKSUM_EN
        chk({tag, "_csum"}, csumErrCount, m_csum);
        chk({tag, "_csum_sat"}, s_csum, sat(m_csum));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        do_reset();
        idle(2);
        check_counts("reset");

        fr.delete();
        for (int i = 1; i <= 16; i++) fr.push_back(8'(i));
        if (FRAME > PB) fr.push_back(8'h10);
        send(100, 1'b1);
        idle(1);
        chk("ordered_frame", packetOut, 128'h0102030405060708090a0b0c0d0e0f10);
        idle(2);
        check_counts("ordered");

        make_frame(5);  send(100, 1'b1);
        make_good();    send(100, 1'b1);
        idle(2);
        check_counts("runt");

        make_frame(20); send(100, 1'b1);
        make_good();    send(100, 1'b1);
        idle(2);
        check_counts("long");

        make_good(); send(50, 1'b1);
        make_good(); send(100, 1'b1);
        make_good(); send(100, 1'b1);
        idle(2);
        check_counts("stall");

`ifdef PKT_CHECKSUM_EN
        fr.delete();
        for (int i = 1; i <= 16; i++) fr.push_back(8'(i));
        fr.push_back(8'h11);
        send(100, 1'b1);
        idle(2);
        check_counts("bad_trailer");
`endif

        make_frame(8); send(100, 1'b0);
        idle(1);
        do_reset();
        make_good(); send(100, 1'b1);
        idle(2);
        check_counts("mid_reset");

        for (int k = 0; k < 20; k++) begin
            make_frame($urandom_range(1, PB - 1));
            send(100, 1'b1);
        end
        for (int k = 0; k < 17; k++) begin
            make_frame($urandom_range(FRAME + 1, FRAME + 5));
            send(100, 1'b1);
        end
        idle(2);
        check_counts("saturate");

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(3))
                0: len = $urandom_range(1, FRAME - 1);
                1: len = $urandom_range(FRAME + 1, FRAME + 6);
                default: len = -1;
            endcase
            if (len < 0) make_good();
            else         make_frame(len);
            if (FRAME > PB && len == FRAME) fr[PB] = 8'($urandom);
            send($urandom_range(30, 100), 1'b1);
            idle($urandom_range(0, 2));
        end
        idle(2);
        check_counts("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
